// File: rtl/if_stage_pkg.sv
// Shared constants for the fetch stage: instruction width, terminator encoding
// and the fetch FSM state encoding.
package if_stage_pkg;

  localparam int          INSTRUCTION_LEN = 32;
  localparam logic [31:0] HALT_WORD_ENC   = 32'hEAFF_FFFF;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } if_state_e;

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register. Flush beats load, load beats hold; a bubble clears
// pc, instruction and valid.
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_i,
  input  logic                       flush_i,
  input  logic [ADDR_W-1:0]          pc_i,
  input  logic [INSTRUCTION_LEN-1:0] instr_i,
  output logic [ADDR_W-1:0]          id_pc,
  output logic [INSTRUCTION_LEN-1:0] id_instr,
  output logic                       id_valid
);

  logic [ADDR_W-1:0]          pc_q, pc_d;
  logic [INSTRUCTION_LEN-1:0] instr_q, instr_d;
  logic                       valid_q, valid_d;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (flush_i) begin
      pc_d    = '0;
      instr_d = '0;
      valid_d = 1'b0;
    end else if (load_i) begin
      pc_d    = pc_i;
      instr_d = instr_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign id_pc    = pc_q;
  assign id_instr = instr_q;
  assign id_valid = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, next-PC mux, boot/run/halt FSM and fetch counter.
// state | meaning
// BOOT  | one post-reset slot, no read, bubble into IF/ID
// RUN   | fetching; branch > freeze > halt word > sequential
// HALT  | stopped on branch-to-self; only a redirect restarts fetch
module if_stage
  import if_stage_pkg::*;
#(
  parameter int                         ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]          RESET_PC  = '0,
  parameter logic [INSTRUCTION_LEN-1:0] HALT_WORD = HALT_WORD_ENC
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       freeze_i,
  input  logic                       branch_taken_i,
  input  logic [ADDR_W-1:0]          branch_addr_i,
  output logic [ADDR_W-1:0]          imem_address,
  output logic                       imem_read,
  input  logic [INSTRUCTION_LEN-1:0] imem_data,
  output logic [ADDR_W-1:0]          id_pc,
  output logic [INSTRUCTION_LEN-1:0] id_instr,
  output logic                       id_valid,
  output logic                       halted,
  output logic [15:0]                fetch_count
);

  if_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              ifid_load, ifid_flush;
  logic [ADDR_W-1:0] pc_plus4, branch_tgt;

  assign pc_plus4   = pc_q + ADDR_W'(4);
  assign branch_tgt = branch_addr_i & {{(ADDR_W-2){1'b1}}, 2'b00};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    imem_read  = 1'b0;
    halted     = 1'b0;
    unique case (state_q)
      ST_BOOT: begin
        ifid_flush = 1'b1;
        state_d    = ST_RUN;
      end
      ST_RUN: begin
        imem_read = 1'b1;
        if (branch_taken_i) begin
          pc_d       = branch_tgt;
          ifid_flush = 1'b1;
        end else if (freeze_i) begin
          pc_d = pc_q;
        end else if (imem_data == HALT_WORD) begin
          ifid_load = 1'b1;
          state_d   = ST_HALT;
        end else begin
          ifid_load = 1'b1;
          pc_d      = pc_plus4;
        end
      end
      ST_HALT: begin
        halted = 1'b1;
        if (branch_taken_i) begin
          pc_d       = branch_tgt;
          ifid_flush = 1'b1;
          state_d    = ST_RUN;
        end else if (!freeze_i) begin
          ifid_flush = 1'b1;
        end
      end
      default: state_d = ST_BOOT;
    endcase
    cnt_d = ifid_load ? cnt_q + 16'd1 : cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  if_id_reg #(.ADDR_W(ADDR_W)) u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .load_i   (ifid_load),
    .flush_i  (ifid_flush),
    .pc_i     (pc_plus4),
    .instr_i  (imem_data),
    .id_pc    (id_pc),
    .id_instr (id_instr),
    .id_valid (id_valid)
  );

  assign imem_address = pc_q;
  assign fetch_count  = cnt_q;

endmodule
